// File: rtl/ysyx_23060020_pkg.sv
// Shared definitions for the ysyx_23060020 execute stage: default width, ALU opcodes and
// the input-buffer occupancy encoding.
package ysyx_23060020_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SLL  = 4'd6;
  localparam logic [3:0] ALU_SRL  = 4'd7;
  localparam logic [3:0] ALU_SRA  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;
  localparam logic [3:0] ALU_SLT  = 4'd10;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } ibuf_state_e;

endpackage

// File: rtl/ysyx_23060020_exu_slot.sv
// One payload register of the execute input buffer, with load enable and optional writeback
// operand patching (enabled by YSYX_23060020_WB_BYPASS_EN).
module ysyx_23060020_exu_slot
  import ysyx_23060020_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned SELW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            valid,
  input  logic [XLEN-1:0] d_pc,
  input  logic [XLEN-1:0] d_alua,
  input  logic [XLEN-1:0] d_alub,
  input  logic [SELW-1:0] d_alusel,
  input  logic [4:0]      d_rd,
  input  logic [4:0]      d_rs1,
  input  logic [4:0]      d_rs2,
  input  logic            d_rs1_use,
  input  logic            d_rs2_use,
  input  logic            d_wen,
  input  logic            wb_wen,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] q_pc,
  output logic [XLEN-1:0] q_alua,
  output logic [XLEN-1:0] q_alub,
  output logic [SELW-1:0] q_alusel,
  output logic [4:0]      q_rd,
  output logic [4:0]      q_rs1,
  output logic [4:0]      q_rs2,
  output logic            q_rs1_use,
  output logic            q_rs2_use,
  output logic            q_wen,
  output logic            q_illegal
);

  logic [XLEN-1:0] pc_q, alua_q, alub_q, alua_d, alub_d;
  logic [SELW-1:0] alusel_q;
  logic [4:0]      rd_q;
  logic            wen_q, illegal_q, illegal_d;

  assign illegal_d = (d_alusel == '0) || (d_alusel > SELW'(ALU_SLT));

`ifdef YSYX_23060020_WB_BYPASS_EN
  logic [4:0] rs1_q, rs2_q, rs1_src, rs2_src;
  logic       rs1_use_q, rs2_use_q, rs1_use_src, rs2_use_src;

  // Patch sources follow whichever register indices the slot holds after this edge.
  assign rs1_src     = load ? d_rs1 : rs1_q;
  assign rs2_src     = load ? d_rs2 : rs2_q;
  assign rs1_use_src = load ? d_rs1_use : rs1_use_q;
  assign rs2_use_src = load ? d_rs2_use : rs2_use_q;
`endif

  always_comb begin
    alua_d = alua_q;
    alub_d = alub_q;
    if (load) begin
      alua_d = d_alua;
      alub_d = d_alub;
    end
`ifdef YSYX_23060020_WB_BYPASS_EN
    if ((load || valid) && rs1_use_src && wb_wen && (wb_rd == rs1_src) && (rs1_src != 5'd0)) begin
      alua_d = wb_data;
    end
    if ((load || valid) && rs2_use_src && wb_wen && (wb_rd == rs2_src) && (rs2_src != 5'd0)) begin
      alub_d = wb_data;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= '0;
      alua_q    <= '0;
      alub_q    <= '0;
      alusel_q  <= '0;
      rd_q      <= '0;
      wen_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      alua_q <= alua_d;
      alub_q <= alub_d;
      if (load) begin
        pc_q      <= d_pc;
        alusel_q  <= d_alusel;
        rd_q      <= d_rd;
        wen_q     <= d_wen;
        illegal_q <= illegal_d;
      end
    end
  end

`ifdef YSYX_23060020_WB_BYPASS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs1_q     <= '0;
      rs2_q     <= '0;
      rs1_use_q <= 1'b0;
      rs2_use_q <= 1'b0;
    end else if (load) begin
      rs1_q     <= d_rs1;
      rs2_q     <= d_rs2;
      rs1_use_q <= d_rs1_use;
      rs2_use_q <= d_rs2_use;
    end
  end

  assign q_rs1     = rs1_q;
  assign q_rs2     = rs2_q;
  assign q_rs1_use = rs1_use_q;
  assign q_rs2_use = rs2_use_q;
`else
  logic unused_bypass;
  assign unused_bypass = ^{valid, d_rs1, d_rs2, d_rs1_use, d_rs2_use, wb_wen, wb_rd, wb_data};

  assign q_rs1     = '0;
  assign q_rs2     = '0;
  assign q_rs1_use = 1'b0;
  assign q_rs2_use = 1'b0;
`endif

  assign q_pc      = pc_q;
  assign q_alua    = alua_q;
  assign q_alub    = alub_q;
  assign q_alusel  = alusel_q;
  assign q_rd      = rd_q;
  assign q_wen     = wen_q;
  assign q_illegal = illegal_q;

endmodule

// File: rtl/ysyx_23060020_exu_ibuf.sv
// Execute-stage input buffer: two-entry skid buffer (MAIN drives out_*, SKID absorbs one op)
// giving a registered in_ready. Writeback operand patching under YSYX_23060020_WB_BYPASS_EN.
module ysyx_23060020_exu_ibuf #(
  parameter int unsigned XLEN = ysyx_23060020_pkg::XLEN,
  parameter int unsigned SELW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_alua,
  input  logic [XLEN-1:0] in_alub,
  input  logic [SELW-1:0] in_alusel,
  input  logic [4:0]      in_rd,
  input  logic [4:0]      in_rs1,
  input  logic [4:0]      in_rs2,
  input  logic            in_rs1_use,
  input  logic            in_rs2_use,
  input  logic            in_wen,
  input  logic            wb_wen,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_alua,
  output logic [XLEN-1:0] out_alub,
  output logic [SELW-1:0] out_alusel,
  output logic [4:0]      out_rd,
  output logic            out_wen,
  output logic            out_illegal
);

  import ysyx_23060020_pkg::*;

  ibuf_state_e state_q, state_d;
  logic in_fire, out_fire, main_load, skid_load, main_from_skid;

  assign in_ready  = (state_q != StTwo);
  assign out_valid = (state_q != StEmpty);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  always_comb begin
    state_d   = state_q;
    main_load = 1'b0;
    skid_load = 1'b0;
    unique case (state_q)
      StEmpty: begin
        if (in_fire) begin
          state_d   = StOne;
          main_load = 1'b1;
        end
      end
      StOne: begin
        if (in_fire && out_fire) begin
          main_load = 1'b1;
        end else if (out_fire) begin
          state_d = StEmpty;
        end else if (in_fire) begin
          state_d   = StTwo;
          skid_load = 1'b1;
        end
      end
      StTwo: begin
        if (out_fire) begin
          state_d   = StOne;
          main_load = 1'b1;
        end
      end
      default: state_d = StEmpty;
    endcase
    // Redirect drops both entries but leaves payload registers untouched.
    if (flush) begin
      state_d   = StEmpty;
      main_load = 1'b0;
      skid_load = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  assign main_from_skid = (state_q == StTwo);

  logic [XLEN-1:0] skid_pc, skid_alua, skid_alub;
  logic [SELW-1:0] skid_alusel;
  logic [4:0]      skid_rd, skid_rs1, skid_rs2;
  logic            skid_rs1_use, skid_rs2_use, skid_wen, unused_skid_illegal;

  logic [XLEN-1:0] main_d_pc, main_d_alua, main_d_alub;
  logic [SELW-1:0] main_d_alusel;
  logic [4:0]      main_d_rd, main_d_rs1, main_d_rs2;
  logic            main_d_rs1_use, main_d_rs2_use, main_d_wen;

  always_comb begin
    main_d_pc      = in_pc;
    main_d_alua    = in_alua;
    main_d_alub    = in_alub;
    main_d_alusel  = in_alusel;
    main_d_rd      = in_rd;
    main_d_rs1     = in_rs1;
    main_d_rs2     = in_rs2;
    main_d_rs1_use = in_rs1_use;
    main_d_rs2_use = in_rs2_use;
    main_d_wen     = in_wen;
    if (main_from_skid) begin
      main_d_pc      = skid_pc;
      main_d_alua    = skid_alua;
      main_d_alub    = skid_alub;
      main_d_alusel  = skid_alusel;
      main_d_rd      = skid_rd;
      main_d_rs1     = skid_rs1;
      main_d_rs2     = skid_rs2;
      main_d_rs1_use = skid_rs1_use;
      main_d_rs2_use = skid_rs2_use;
      main_d_wen     = skid_wen;
    end
  end

  logic [4:0] unused_main_rs1, unused_main_rs2;
  logic       unused_main_rs1_use, unused_main_rs2_use;

  ysyx_23060020_exu_slot #(
    .XLEN (XLEN),
    .SELW (SELW)
  ) u_main (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (main_load),
    .valid     (state_q != StEmpty),
    .d_pc      (main_d_pc),
    .d_alua    (main_d_alua),
    .d_alub    (main_d_alub),
    .d_alusel  (main_d_alusel),
    .d_rd      (main_d_rd),
    .d_rs1     (main_d_rs1),
    .d_rs2     (main_d_rs2),
    .d_rs1_use (main_d_rs1_use),
    .d_rs2_use (main_d_rs2_use),
    .d_wen     (main_d_wen),
    .wb_wen    (wb_wen),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .q_pc      (out_pc),
    .q_alua    (out_alua),
    .q_alub    (out_alub),
    .q_alusel  (out_alusel),
    .q_rd      (out_rd),
    .q_rs1     (unused_main_rs1),
    .q_rs2     (unused_main_rs2),
    .q_rs1_use (unused_main_rs1_use),
    .q_rs2_use (unused_main_rs2_use),
    .q_wen     (out_wen),
    .q_illegal (out_illegal)
  );

  ysyx_23060020_exu_slot #(
    .XLEN (XLEN),
    .SELW (SELW)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (skid_load),
    .valid     (state_q == StTwo),
    .d_pc      (in_pc),
    .d_alua    (in_alua),
    .d_alub    (in_alub),
    .d_alusel  (in_alusel),
    .d_rd      (in_rd),
    .d_rs1     (in_rs1),
    .d_rs2     (in_rs2),
    .d_rs1_use (in_rs1_use),
    .d_rs2_use (in_rs2_use),
    .d_wen     (in_wen),
    .wb_wen    (wb_wen),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .q_pc      (skid_pc),
    .q_alua    (skid_alua),
    .q_alub    (skid_alub),
    .q_alusel  (skid_alusel),
    .q_rd      (skid_rd),
    .q_rs1     (skid_rs1),
    .q_rs2     (skid_rs2),
    .q_rs1_use (skid_rs1_use),
    .q_rs2_use (skid_rs2_use),
    .q_wen     (skid_wen),
    .q_illegal (unused_skid_illegal)
  );

endmodule

// File: tb/tb_ysyx_23060020_exu_ibuf.sv
// Bench for ysyx_23060020_exu_ibuf: directed scenarios plus a randomized run against a
// queue-based model. Bypass checks are active when YSYX_23060020_WB_BYPASS_EN is defined.
module tb_ysyx_23060020_exu_ibuf;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0, in_alua = '0, in_alub = '0;
  logic [3:0]  in_alusel = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic        in_rs1_use = 1'b0, in_rs2_use = 1'b0, in_wen = 1'b0;
  logic        wb_wen = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc, out_alua, out_alub;
  logic [3:0]  out_alusel;
  logic [4:0]  out_rd;
  logic        out_wen, out_illegal;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic [31:0] pc, a, b;
    logic [3:0]  sel;
    logic [4:0]  rd, rs1, rs2;
    logic        u1, u2, wen;
  } op_t;

  op_t model_q[$];

  always #5 clk = ~clk;

  ysyx_23060020_exu_ibuf #(
    .XLEN (32),
    .SELW (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pc      (in_pc),
    .in_alua    (in_alua),
    .in_alub    (in_alub),
    .in_alusel  (in_alusel),
    .in_rd      (in_rd),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_rs1_use (in_rs1_use),
    .in_rs2_use (in_rs2_use),
    .in_wen     (in_wen),
    .wb_wen     (wb_wen),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pc     (out_pc),
    .out_alua   (out_alua),
    .out_alub   (out_alub),
    .out_alusel (out_alusel),
    .out_rd     (out_rd),
    .out_wen    (out_wen),
    .out_illegal(out_illegal)
  );

  task automatic offer(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] sel, input logic [4:0] rs1, input logic u1);
    in_valid   = 1'b1;
    in_pc      = pc;
    in_alua    = a;
    in_alub    = b;
    in_alusel  = sel;
    in_rd      = 5'd1;
    in_rs1     = rs1;
    in_rs2     = 5'd0;
    in_rs1_use = u1;
    in_rs2_use = 1'b0;
    in_wen     = 1'b1;
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    offer(32'hdead, 32'h11, 32'h22, 4'd3, 5'd0, 1'b0);
    out_ready = 1'b1;
    cycle();
    cycle();
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid);
    else n_pass++;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready);
    else n_pass++;
    n_total++;
    if ({out_pc, out_alua, out_alub, out_alusel, out_rd, out_wen, out_illegal} !== '0)
      $display("FAIL reset_payload got %h/%h/%h/%h/%h/%b/%b want all zero",
               out_pc, out_alua, out_alub, out_alusel, out_rd, out_wen, out_illegal);
    else n_pass++;
    in_valid = 1'b0;
    rst_n = 1'b1;
    cycle();
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL reset_release_valid got %b want 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_basic();
    offer(32'h100, 32'd5, 32'd7, 4'd1, 5'd0, 1'b0);
    out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    n_total++;
    if (out_valid !== 1'b1 || out_alua !== 32'd5 || out_alub !== 32'd7 || out_pc !== 32'h100)
      $display("FAIL basic_latency got v=%b a=%0d b=%0d pc=%h want v=1 a=5 b=7 pc=100",
               out_valid, out_alua, out_alub, out_pc);
    else n_pass++;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL basic_in_ready got %b want 1", in_ready);
    else n_pass++;
    cycle();
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL basic_drain got %b want 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    offer(32'h200, 32'hA, 32'h0, 4'd2, 5'd0, 1'b0);
    cycle();
    offer(32'h204, 32'hB, 32'h0, 4'd2, 5'd0, 1'b0);
    cycle();
    n_total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_alua !== 32'hA)
      $display("FAIL b2b_full got rdy=%b v=%b a=%h want rdy=0 v=1 a=a", in_ready, out_valid,
               out_alua);
    else n_pass++;
    offer(32'h208, 32'hC, 32'h0, 4'd2, 5'd0, 1'b0);
    cycle();
    n_total++;
    if (out_alua !== 32'hA || in_ready !== 1'b0)
      $display("FAIL b2b_stall got a=%h rdy=%b want a=a rdy=0", out_alua, in_ready);
    else n_pass++;
    out_ready = 1'b1;
    cycle();
    n_total++;
    if (out_alua !== 32'hB || out_pc !== 32'h204 || in_ready !== 1'b1)
      $display("FAIL b2b_second got a=%h pc=%h rdy=%b want a=b pc=204 rdy=1", out_alua, out_pc,
               in_ready);
    else n_pass++;
    cycle();
    in_valid = 1'b0;
    n_total++;
    if (out_alua !== 32'hC || out_valid !== 1'b1)
      $display("FAIL b2b_third got a=%h v=%b want a=c v=1", out_alua, out_valid);
    else n_pass++;
    cycle();
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL b2b_empty got %b want 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    offer(32'h300, 32'h1, 32'h0, 4'd1, 5'd0, 1'b0);
    cycle();
    cycle();
    flush = 1'b1;
    offer(32'h308, 32'h55, 32'h0, 4'd1, 5'd0, 1'b0);
    cycle();
    flush = 1'b0;
    in_valid = 1'b0;
    n_total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL flush_state got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
    else n_pass++;
    cycle();
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL flush_no_capture got v=%b want 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_illegal();
    logic [3:0] sels[5];
    logic       exp;
    sels = '{4'd0, 4'd11, 4'd10, 4'd15, 4'd1};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      offer(32'h400 + 32'(i), 32'h0, 32'h0, sels[i], 5'd0, 1'b0);
      cycle();
      exp = (sels[i] == 4'd0) || (sels[i] > 4'd10);
      n_total++;
      if (out_illegal !== exp || out_alusel !== sels[i])
        $display("FAIL illegal_sel%0d got ill=%b sel=%0d want ill=%b sel=%0d", sels[i],
                 out_illegal, out_alusel, exp, sels[i]);
      else n_pass++;
    end
    in_valid = 1'b0;
    cycle();
  endtask

  task automatic test_bypass();
`ifdef YSYX_23060020_WB_BYPASS_EN
    out_ready = 1'b0;
    offer(32'h500, 32'h0, 32'h9, 4'd1, 5'd3, 1'b1);
    cycle();
    in_valid = 1'b0;
    wb_wen = 1'b1;
    wb_rd = 5'd3;
    wb_data = 32'h1234;
    cycle();
    wb_wen = 1'b0;
    n_total++;
    if (out_alua !== 32'h1234 || out_alub !== 32'h9)
      $display("FAIL bypass_hit got a=%h b=%h want a=1234 b=9", out_alua, out_alub);
    else n_pass++;
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    offer(32'h504, 32'h77, 32'h0, 4'd1, 5'd0, 1'b1);
    cycle();
    in_valid = 1'b0;
    wb_wen = 1'b1;
    wb_rd = 5'd0;
    cycle();
    wb_wen = 1'b0;
    n_total++;
    if (out_alua !== 32'h77) $display("FAIL bypass_x0 got a=%h want 77", out_alua);
    else n_pass++;
    out_ready = 1'b1;
    cycle();
`endif
  endtask

  task automatic test_random();
    op_t nop;
    logic in_f, out_f, exp_ill;
    out_ready = 1'b1;
    flush = 1'b1;
    in_valid = 1'b0;
    cycle();
    flush = 1'b0;
    model_q.delete();
    for (int c = 0; c < 400; c++) begin
      n_total++;
      if (out_valid !== (model_q.size() > 0) || in_ready !== (model_q.size() < 2))
        $display("FAIL rand_hs cyc%0d got v=%b rdy=%b want v=%b rdy=%b", c, out_valid,
                 in_ready, model_q.size() > 0, model_q.size() < 2);
      else n_pass++;
      if (model_q.size() > 0) begin
        exp_ill = (model_q[0].sel == 4'd0) || (model_q[0].sel > 4'd10);
        n_total++;
        if (out_pc !== model_q[0].pc || out_alua !== model_q[0].a || out_alub !== model_q[0].b ||
            out_alusel !== model_q[0].sel || out_rd !== model_q[0].rd ||
            out_wen !== model_q[0].wen || out_illegal !== exp_ill)
          $display("FAIL rand_payload cyc%0d got pc=%h a=%h b=%h sel=%h rd=%0d w=%b ill=%b want pc=%h a=%h b=%h sel=%h rd=%0d w=%b ill=%b",
                   c, out_pc, out_alua, out_alub, out_alusel, out_rd, out_wen, out_illegal,
                   model_q[0].pc, model_q[0].a, model_q[0].b, model_q[0].sel, model_q[0].rd,
                   model_q[0].wen, exp_ill);
        else n_pass++;
      end
      flush      = ($urandom_range(0, 19) == 0);
      in_valid   = ($urandom_range(0, 2) != 0);
      out_ready  = ($urandom_range(0, 2) != 0);
      in_pc      = $urandom;
      in_alua    = $urandom;
      in_alub    = $urandom;
      in_alusel  = 4'($urandom_range(0, 15));
      in_rd      = 5'($urandom_range(0, 31));
      in_rs1     = 5'($urandom_range(0, 3));
      in_rs2     = 5'($urandom_range(0, 3));
      in_rs1_use = 1'($urandom_range(0, 1));
      in_rs2_use = 1'($urandom_range(0, 1));
      in_wen     = 1'($urandom_range(0, 1));
      wb_wen     = 1'($urandom_range(0, 1));
      wb_rd      = 5'($urandom_range(0, 3));
      wb_data    = $urandom;
      nop = '{pc: in_pc, a: in_alua, b: in_alub, sel: in_alusel, rd: in_rd, rs1: in_rs1,
              rs2: in_rs2, u1: in_rs1_use, u2: in_rs2_use, wen: in_wen};
      in_f  = in_valid && (model_q.size() < 2);
      out_f = out_ready && (model_q.size() > 0);
      @(posedge clk);
      if (flush) begin
        model_q.delete();
      end else begin
        if (out_f) void'(model_q.pop_front());
        if (in_f) model_q.push_back(nop);
      end
`ifdef YSYX_23060020_WB_BYPASS_EN
      foreach (model_q[i]) begin
        if (model_q[i].u1 && wb_wen && wb_rd == model_q[i].rs1 && model_q[i].rs1 != 5'd0)
          model_q[i].a = wb_data;
        if (model_q[i].u2 && wb_wen && wb_rd == model_q[i].rs2 && model_q[i].rs2 != 5'd0)
          model_q[i].b = wb_data;
      end
`endif
      @(negedge clk);
    end
    flush = 1'b0;
    in_valid = 1'b0;
    wb_wen = 1'b0;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    offer(32'h600, 32'hAA, 32'hBB, 4'd5, 5'd0, 1'b0);
    cycle();
    cycle();
    in_valid = 1'b0;
    n_total++;
    if (in_ready !== 1'b0) $display("FAIL rstmid_full got rdy=%b want 0", in_ready);
    else n_pass++;
    #1 rst_n = 1'b0;
    #1;
    n_total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_alua !== 32'h0 || out_pc !== 32'h0)
      $display("FAIL rstmid_async got v=%b rdy=%b a=%h pc=%h want v=0 rdy=1 a=0 pc=0",
               out_valid, in_ready, out_alua, out_pc);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL rstmid_after got v=%b want 0", out_valid);
    else n_pass++;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_back_to_back();
    test_flush();
    test_illegal();
    test_bypass();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ysyx_23060020_exu_ibuf.md
# ysyx_23060020_exu_ibuf

Execute-stage input buffer between the decode unit and the ALU. Registers one decoded ALU operation per handshake (operands, opcode, destination, PC), gives the decoder a registered `in_ready` via a two-entry skid buffer, and presents a stable operation to the ALU and writeback path. Optionally patches held operands with the writeback result so stalled entries never carry stale register values.

## Interface
Parameters:
- `XLEN`, 32, operand and PC width
- `SELW`, 4, ALU opcode width

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `flush`  in  1  discard all held entries (branch redirect)
- `in_valid`  in  1  decode offers an operation
- `in_ready`  out  1  buffer accepts; depends on state only
- `in_pc`, `in_alua`, `in_alub`  in  XLEN  PC, operand A, operand B
- `in_alusel`  in  SELW  ALU opcode
- `in_rd`, `in_rs1`, `in_rs2`  in  5  destination and source register indices
- `in_rs1_use`, `in_rs2_use`  in  1  operand A/B comes from rs1/rs2 (not imm/PC)
- `in_wen`  in  1  result written to `rd`
- `wb_wen`  in  1  writeback writes this cycle
- `wb_rd`  in  5  writeback index
- `wb_data`  in  XLEN  writeback value
- `out_valid`  out  1  operation available to ALU
- `out_ready`  in  1  downstream consumes
- `out_pc`, `out_alua`, `out_alub`  out  XLEN  registered payload
- `out_alusel`  out  SELW  registered opcode
- `out_rd`  out  5; `out_wen`  out  1
- `out_illegal`  out  1  held opcode is outside 4'd1..4'd10

## Operation
- Two slots: MAIN (drives `out_*`) and SKID. States: EMPTY, ONE (MAIN valid), TWO (both valid).
- `in_ready` = (state != TWO). `out_valid` = (state != EMPTY). in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- EMPTY: in_fire -> ONE, MAIN <= in.
- ONE: in_fire & out_fire -> ONE, MAIN <= in; out_fire only -> EMPTY; in_fire only -> TWO, SKID <= in.
- TWO: out_fire -> ONE, MAIN <= SKID; in_valid ignored.
- `flush` dominates: next state EMPTY regardless of in_fire/out_fire; payload registers keep their values.
- Order preserved; no entry dropped or duplicated except by flush.
- `out_illegal` registered with MAIN: 1 when opcode is 4'd0 or 4'd11..4'd15. Opcode passes unchanged; the ALU outputs 0 for such codes.
- Opcode map (for `out_illegal` only): 1 add, 2 sub, 3 and, 4 or, 5 xor, 6 sll, 7 srl, 8 sra, 9 sltu, 10 slt.

## Timing
- Reset (async assert, sync release): state EMPTY; `out_valid`=0, `in_ready`=1, all payload outputs 0, `out_illegal`=0. in_valid during reset ignored.
- Latency: in_fire in cycle N -> `out_valid`=1 in cycle N+1 (from EMPTY). Throughput one op/cycle when `out_ready` stays high.
- `out_*` payload stable while out_valid & !out_ready, except bypass patch below.
- Reset mid-operation: both slots discarded immediately.

## Configuration
- `YSYX_23060020_WB_BYPASS_EN` defined: any write into MAIN or SKID (from `in_*` or SKID->MAIN), and every cycle a slot is held, substitutes `wb_data` for operand A when rs1_use & wb_wen & wb_rd==rs1 & rs1!=0; same for B/rs2. rs1/rs2/use bits stored per slot.
- Undefined: operands stored verbatim; `wb_*` ports present but unused; rs/use bits not stored.

## Structure
- Shared package `ysyx_23060020_pkg`: opcode constants (ALU_ADD=4'd1 .. ALU_SLT=4'd10), state encoding, XLEN.
- One sub-module natural: `ysyx_23060020_exu_slot` (one payload register with load enable and bypass patch), instantiated twice.

## Test plan
- Reset then in_valid=1, alua=5, alub=7, alusel=1, out_ready=1 -> next cycle out_valid=1, out_alua=5, out_alub=7, in_ready stays 1.
- out_ready=0, push ops A, B -> after B state TWO, in_ready=0; op C held at input; out_ready=1 -> A, B, C emerge in order on consecutive fires.
- TWO state, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1; the offered op is not captured.
- BYPASS_EN: held op rs1=3, rs1_use=1, alua=0; wb_wen=1, wb_rd=3, wb_data=0x1234 -> next cycle out_alua=0x1234; repeat with rs1=0 -> out_alua unchanged.
- alusel=4'd0 and 4'd11 -> out_illegal=1; alusel=4'd10 -> out_illegal=0.
- Assert rst_n low while in TWO -> out_valid=0, in_ready=1, payload 0 immediately, before next clk edge.
